// File: rtl/banked_weight_buffer_if.sv
// -----------------------------------------------------------------------------
// banked_weight_buffer_if
// Bundles the compute read port, host write port, prefetch control, external
// memory read channel and swap/status signals of banked_weight_buffer.
//   slave  : the weight buffer itself
//   master : the surrounding logic (controller, memory, array, testbench)
// -----------------------------------------------------------------------------
interface banked_weight_buffer_if #(
    parameter int DATA_BITS     = 16,
    parameter int NUM_BANKS     = 4,
    parameter int BANK_DEPTH    = 1024,
    parameter int EXT_ADDR_BITS = 16
);
    localparam int BANK_BITS = $clog2(NUM_BANKS);
    localparam int ADDR_BITS = $clog2(BANK_DEPTH);

    // compute read port
    logic                     rd_en;
    logic [BANK_BITS-1:0]     rd_bank;
    logic [ADDR_BITS-1:0]     rd_addr;
    logic [DATA_BITS-1:0]     rd_data;
    logic                     rd_valid;
    // host write port (shadow buffer)
    logic                     wr_en;
    logic [BANK_BITS-1:0]     wr_bank;
    logic [ADDR_BITS-1:0]     wr_addr;
    logic [DATA_BITS-1:0]     wr_data;
    logic                     wr_conflict;
    // prefetch control
    logic                     pf_start;
    logic [BANK_BITS-1:0]     pf_bank;
    logic [ADDR_BITS-1:0]     pf_local_addr;
    logic [EXT_ADDR_BITS-1:0] pf_ext_addr;
    logic [ADDR_BITS:0]       pf_len;
    logic                     pf_busy;
    logic                     pf_done;
    // external memory read channel
    logic                     mem_read_valid;
    logic [EXT_ADDR_BITS-1:0] mem_read_address;
    logic                     mem_read_ready;
    logic [DATA_BITS-1:0]     mem_read_data;
    // swap / status
    logic                     swap_req;
    logic                     swap_pending;
    logic                     active_buffer;
    logic                     parity_err;

    modport slave (
        input  rd_en, rd_bank, rd_addr,
        output rd_data, rd_valid,
        input  wr_en, wr_bank, wr_addr, wr_data,
        output wr_conflict,
        input  pf_start, pf_bank, pf_local_addr, pf_ext_addr, pf_len,
        output pf_busy, pf_done,
        output mem_read_valid, mem_read_address,
        input  mem_read_ready, mem_read_data,
        input  swap_req,
        output swap_pending, active_buffer, parity_err
    );

    modport master (
        output rd_en, rd_bank, rd_addr,
        input  rd_data, rd_valid,
        output wr_en, wr_bank, wr_addr, wr_data,
        input  wr_conflict,
        output pf_start, pf_bank, pf_local_addr, pf_ext_addr, pf_len,
        input  pf_busy, pf_done,
        input  mem_read_valid, mem_read_address,
        output mem_read_ready, mem_read_data,
        output swap_req,
        input  swap_pending, active_buffer, parity_err
    );
endinterface

// File: rtl/banked_weight_buffer.sv
// -----------------------------------------------------------------------------
// banked_weight_buffer
// Double-buffered, banked weight store. Compute reads the active buffer with
// one cycle of latency; the host and a built-in prefetch engine fill the
// shadow buffer. Swaps requested while a prefetch runs are held until the
// prefetch has finished.
//
// Ports:
//   clk      : clock
//   reset_n  : asynchronous active-low reset (memory contents are kept)
//   bus      : banked_weight_buffer_if.slave (read, write, prefetch,
//              external memory channel, swap and status signals)
//
// Build option:
//   WEIGHT_BUF_PARITY_EN : store an even-parity bit per entry and flag
//                          mismatches on read via parity_err; when undefined
//                          parity_err is tied low.
//
// Prefetch FSM
//   state   | meaning
//   --------+-----------------------------------------------------------
//   PF_IDLE | waiting for pf_start
//   PF_REQ  | request outstanding on the external channel, filling shadow
//   PF_DONE | one-cycle completion, pf_done high, deferred swap applied
// -----------------------------------------------------------------------------
module banked_weight_buffer #(
    parameter int DATA_BITS     = 16,
    parameter int NUM_BANKS     = 4,
    parameter int BANK_DEPTH    = 1024,
    parameter int EXT_ADDR_BITS = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    banked_weight_buffer_if.slave bus
);
    localparam int BANK_BITS = $clog2(NUM_BANKS);
    localparam int ADDR_BITS = $clog2(BANK_DEPTH);
`ifdef WEIGHT_BUF_PARITY_EN
    localparam int ENTRY_BITS = DATA_BITS + 1;
`else
    localparam int ENTRY_BITS = DATA_BITS;
`endif

    typedef enum logic [1:0] {PF_IDLE, PF_REQ, PF_DONE} pf_state_t;

    logic [ENTRY_BITS-1:0]    mem_q [2][NUM_BANKS][BANK_DEPTH];

    pf_state_t                state_q;
    logic                     pf_buf_q;
    logic [BANK_BITS-1:0]     pf_bank_q;
    logic [ADDR_BITS-1:0]     pf_local_q;
    logic [EXT_ADDR_BITS-1:0] pf_ext_q;
    logic [ADDR_BITS:0]       pf_cnt_q;
    logic                     pf_busy_q;
    logic                     pf_done_q;
    logic                     mem_valid_q;
    logic                     active_q;
    logic                     swap_pending_q;
    logic [DATA_BITS-1:0]     rd_data_q;
    logic                     rd_valid_q;

    logic                     shadow_buf;
    logic                     pf_wr;
    logic                     same_entry;
    logic                     host_wr;
    logic                     swap_toggle;
    logic [ENTRY_BITS-1:0]    rd_entry;

    function automatic logic [ENTRY_BITS-1:0] encode(input logic [DATA_BITS-1:0] d);
`ifdef WEIGHT_BUF_PARITY_EN
        return {^d, d};
`else
        return d;
`endif
    endfunction

    always_comb begin
        shadow_buf = ~active_q;
        pf_wr      = (state_q == PF_REQ) && bus.mem_read_ready;
        same_entry = (pf_buf_q == shadow_buf) && (pf_bank_q == bus.wr_bank)
                     && (pf_local_q == bus.wr_addr);
        // Prefetch owns the entry when both land on it in the same cycle.
        host_wr    = bus.wr_en && !(pf_wr && same_entry);
        // A pending swap fires on the edge leaving DONE; a fresh request while
        // idle fires immediately. Either way only one toggle results.
        swap_toggle = ((state_q == PF_DONE) && swap_pending_q)
                      || (bus.swap_req && !pf_busy_q && !swap_pending_q);
        rd_entry    = mem_q[active_q][bus.rd_bank][bus.rd_addr];
    end

    // Storage: no reset, contents survive reset_n.
    always_ff @(posedge clk) begin
        if (host_wr)
            mem_q[shadow_buf][bus.wr_bank][bus.wr_addr] <= encode(bus.wr_data);
        if (pf_wr)
            mem_q[pf_buf_q][pf_bank_q][pf_local_q] <= encode(bus.mem_read_data);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= PF_IDLE;
            pf_buf_q       <= 1'b0;
            pf_bank_q      <= '0;
            pf_local_q     <= '0;
            pf_ext_q       <= '0;
            pf_cnt_q       <= '0;
            pf_busy_q      <= 1'b0;
            pf_done_q      <= 1'b0;
            mem_valid_q    <= 1'b0;
            active_q       <= 1'b0;
            swap_pending_q <= 1'b0;
        end else begin
            pf_done_q <= 1'b0;
            case (state_q)
                PF_IDLE: begin
                    if (bus.pf_start) begin
                        pf_buf_q   <= shadow_buf;
                        pf_bank_q  <= bus.pf_bank;
                        pf_local_q <= bus.pf_local_addr;
                        pf_ext_q   <= bus.pf_ext_addr;
                        pf_cnt_q   <= bus.pf_len;
                        if (bus.pf_len == '0) begin
                            state_q   <= PF_DONE;
                            pf_done_q <= 1'b1;
                        end else begin
                            state_q     <= PF_REQ;
                            pf_busy_q   <= 1'b1;
                            mem_valid_q <= 1'b1;
                        end
                    end
                end
                PF_REQ: begin
                    if (bus.mem_read_ready) begin
                        pf_local_q <= pf_local_q + 1'b1;
                        pf_ext_q   <= pf_ext_q + 1'b1;
                        pf_cnt_q   <= pf_cnt_q - 1'b1;
                        if (pf_cnt_q == (ADDR_BITS+1)'(1)) begin
                            state_q     <= PF_DONE;
                            pf_busy_q   <= 1'b0;
                            mem_valid_q <= 1'b0;
                            pf_done_q   <= 1'b1;
                        end
                    end
                end
                PF_DONE: state_q <= PF_IDLE;
                default: state_q <= PF_IDLE;
            endcase

            if (swap_toggle)
                active_q <= ~active_q;
            if (state_q == PF_DONE)
                swap_pending_q <= 1'b0;
            else if (bus.swap_req && pf_busy_q)
                swap_pending_q <= 1'b1;
        end
    end

    // Read path samples the pre-swap active buffer on a swap edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= bus.rd_en;
            if (bus.rd_en)
                rd_data_q <= rd_entry[DATA_BITS-1:0];
        end
    end

`ifdef WEIGHT_BUF_PARITY_EN
    logic parity_err_q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            parity_err_q <= 1'b0;
        else
            parity_err_q <= bus.rd_en && (^rd_entry);
    end
    assign bus.parity_err = parity_err_q;
`else
    assign bus.parity_err = 1'b0;
`endif

    assign bus.rd_data          = rd_data_q;
    assign bus.rd_valid         = rd_valid_q;
    assign bus.wr_conflict      = bus.wr_en && pf_wr && same_entry;
    assign bus.pf_busy          = pf_busy_q;
    assign bus.pf_done          = pf_done_q;
    assign bus.mem_read_valid   = mem_valid_q;
    assign bus.mem_read_address = pf_ext_q;
    assign bus.swap_pending     = swap_pending_q;
    assign bus.active_buffer    = active_q;
endmodule

// File: tb/tb_banked_weight_buffer.sv
module tb_banked_weight_buffer;
    localparam int DB    = 16;
    localparam int NB    = 4;
    localparam int DEPTH = 1024;
    localparam int EAB   = 16;
    localparam int BB    = $clog2(NB);
    localparam int AB    = $clog2(DEPTH);

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    banked_weight_buffer_if #(.DATA_BITS(DB), .NUM_BANKS(NB), .BANK_DEPTH(DEPTH),
                              .EXT_ADDR_BITS(EAB)) bus ();

    banked_weight_buffer #(.DATA_BITS(DB), .NUM_BANKS(NB), .BANK_DEPTH(DEPTH),
                           .EXT_ADDR_BITS(EAB)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus));

    typedef struct {
        bit            care;
        logic [DB-1:0] d;
        bit            perr;
    } rd_exp_t;

    int n_vec = 0;
    int n_err = 0;
    int n_done = 0, exp_done = 0;
    int n_conf = 0;
    int ref_act = 0;
    logic [DB-1:0]  ref_mem [2][NB][DEPTH];
    bit             written [2][NB][DEPTH];
    rd_exp_t        rdq[$];
    logic [EAB-1:0] addrq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [DB-1:0] ext_data(input logic [EAB-1:0] a);
        return DB'(a * 16'h9E37) ^ 16'h5A5A;
    endfunction

    function automatic int rand_addr();
        if ($urandom_range(0, 1) == 1) return $urandom_range(0, 15);
        return $urandom_range(DEPTH - 8, DEPTH - 1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.rd_en = 1'b0; bus.wr_en = 1'b0; bus.pf_start = 1'b0; bus.swap_req = 1'b0;
    endtask

    task automatic issue_read(input int b, input int a);
        rd_exp_t e;
        bus.rd_en = 1'b1; bus.rd_bank = BB'(b); bus.rd_addr = AB'(a);
        e.care = written[ref_act][b][a];
        e.d    = ref_mem[ref_act][b][a];
        e.perr = 1'b0;
        rdq.push_back(e);
    endtask

    task automatic issue_write(input int b, input int a, input logic [DB-1:0] d);
        bus.wr_en = 1'b1; bus.wr_bank = BB'(b); bus.wr_addr = AB'(a); bus.wr_data = d;
        ref_mem[1 - ref_act][b][a] = d;
        written[1 - ref_act][b][a] = 1'b1;
    endtask

    // swap_mode: 0 none, 1 random, 2 request in first REQ cycle plus a duplicate
    task automatic do_prefetch(input int b, input int la, input int ea, input int len,
                               input int swap_mode, input bit conflict);
        int sh = 1 - ref_act;
        int cyc = 0;
        bit swapped = 1'b0;
        for (int i = 0; i < len; i++) begin
            ref_mem[sh][b][(la + i) % DEPTH] = ext_data(EAB'(ea + i));
            written[sh][b][(la + i) % DEPTH] = 1'b1;
            addrq.push_back(EAB'(ea + i));
        end
        exp_done++;
        bus.pf_start = 1'b1; bus.pf_bank = BB'(b); bus.pf_local_addr = AB'(la);
        bus.pf_ext_addr = EAB'(ea); bus.pf_len = (AB+1)'(len);
        tick();
        idle();
        while (!bus.pf_done && cyc < 300) begin
            chk("pf_busy_req", bus.pf_busy, 1);
            chk("active_hold_req", bus.active_buffer, ref_act);
            if (cyc == 1) begin
                bus.pf_start = 1'b1; bus.pf_bank = BB'(b ^ 1); bus.pf_ext_addr = 16'hFFFF;
                bus.pf_len = (AB+1)'(3);
            end
            if ($urandom_range(0, 1) == 1) issue_read($urandom_range(0, NB - 1), rand_addr());
            if (conflict) begin
                bus.wr_en = 1'b1; bus.wr_bank = BB'(b); bus.wr_addr = AB'(la);
                bus.wr_data = DB'($urandom);
            end else if ($urandom_range(0, 2) == 0)
                issue_write((b + $urandom_range(1, NB - 1)) % NB, rand_addr(), DB'($urandom));
            if ((swap_mode == 2 && (cyc == 0 || cyc == 2)) ||
                (swap_mode == 1 && $urandom_range(0, 5) == 0)) begin
                bus.swap_req = 1'b1;
                swapped = 1'b1;
            end
            tick();
            idle();
            cyc++;
        end
        if (!bus.pf_done) begin
            n_vec++; n_err++;
            $display("FAIL pf_done_timeout: got no pf_done expected pf_done within 300 cycles");
            return;
        end
        if (len == 0) chk("pf_len0_latency", cyc, 0);
        chk("swap_pending_done", bus.swap_pending, swapped);
        chk("pf_busy_done", bus.pf_busy, 0);
        chk("mem_valid_done", bus.mem_read_valid, 0);
        chk("active_hold_done", bus.active_buffer, ref_act);
        issue_read($urandom_range(0, NB - 1), rand_addr());
        if (swap_mode == 1 && $urandom_range(0, 3) == 0) begin
            bus.swap_req = 1'b1;
            swapped = 1'b1;
        end
        tick();
        idle();
        if (swapped) ref_act = 1 - ref_act;
        chk("active_after_done", bus.active_buffer, ref_act);
        chk("swap_pending_clear", bus.swap_pending, 0);
        chk("pf_done_single", bus.pf_done, 0);
    endtask

    // external memory responder
    initial begin
        bus.mem_read_ready = 1'b0;
        bus.mem_read_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!reset_n || bus.mem_read_ready)
                bus.mem_read_ready = 1'b0;
            else if (bus.mem_read_valid && $urandom_range(0, 2) != 0) begin
                bus.mem_read_ready = 1'b1;
                bus.mem_read_data  = ext_data(bus.mem_read_address);
            end
        end
    end

    // monitor / scoreboard
    initial begin
        rd_exp_t e;
        logic [EAB-1:0] ea;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (bus.rd_valid) begin
                    if (rdq.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL rd_unexpected: got rd_valid=1 expected no read in flight");
                    end else begin
                        e = rdq.pop_front();
                        if (e.care) begin
                            chk("rd_data", bus.rd_data, e.d);
                            chk("parity_err", bus.parity_err, e.perr);
                        end
                    end
                end
                if (bus.mem_read_valid && bus.mem_read_ready) begin
                    if (addrq.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL mem_addr_unexpected: got addr %0h expected no request",
                                 bus.mem_read_address);
                    end else begin
                        ea = addrq.pop_front();
                        chk("mem_read_address", bus.mem_read_address, ea);
                    end
                end
                if (bus.pf_done) n_done++;
                if (bus.wr_conflict) n_conf++;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.rd_en = 0; bus.rd_bank = '0; bus.rd_addr = '0;
        bus.wr_en = 0; bus.wr_bank = '0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.pf_start = 0; bus.pf_bank = '0; bus.pf_local_addr = '0; bus.pf_ext_addr = '0;
        bus.pf_len = '0; bus.swap_req = 0;
        #3;
        chk("rst_rd_valid", bus.rd_valid, 0);
        chk("rst_rd_data", bus.rd_data, 0);
        chk("rst_wr_conflict", bus.wr_conflict, 0);
        chk("rst_pf_busy", bus.pf_busy, 0);
        chk("rst_pf_done", bus.pf_done, 0);
        chk("rst_mem_valid", bus.mem_read_valid, 0);
        chk("rst_active", bus.active_buffer, 0);
        chk("rst_swap_pending", bus.swap_pending, 0);
        chk("rst_parity_err", bus.parity_err, 0);
        #10 reset_n = 1'b1;
        tick();

        // first read: latency one cycle
        issue_read(0, 0);
        tick(); idle();
        chk("rd_valid_latency", bus.rd_valid, 1);
        tick();
        chk("rd_valid_drop", bus.rd_valid, 0);

        // host write to shadow, swap, read back
        issue_write(2, 5, 16'h1234);
        tick(); idle();
        bus.swap_req = 1'b1;
        tick(); idle();
        ref_act = 1 - ref_act;
        chk("swap_idle_active", bus.active_buffer, ref_act);
        issue_read(2, 5);
        tick(); idle();

        // wrapping prefetch with deferred swap and a duplicate request
        do_prefetch(1, DEPTH - 2, 16'h0100, 4, 2, 1'b0);
        for (int i = 0; i < 4; i++) begin
            issue_read(1, (DEPTH - 2 + i) % DEPTH);
            tick(); idle();
        end

        // host/prefetch collision on the same shadow entry
        do_prefetch(3, 7, 16'h0420, 1, 0, 1'b1);
        tick();
        chk("wr_conflict_count", n_conf, 1);
        bus.swap_req = 1'b1; tick(); idle(); ref_act = 1 - ref_act;
        issue_read(3, 7); tick(); idle();

        // zero-length prefetch
        do_prefetch(0, 3, 16'h0800, 0, 0, 1'b0);

        // reset during a prefetch
        bus.pf_start = 1'b1; bus.pf_bank = '0; bus.pf_local_addr = '0;
        bus.pf_ext_addr = 16'h2000; bus.pf_len = (AB+1)'(5);
        tick(); idle();
        chk("pre_reset_mem_valid", bus.mem_read_valid, 1);
        reset_n = 1'b0;
        #1;
        chk("async_reset_mem_valid", bus.mem_read_valid, 0);
        chk("async_reset_pf_busy", bus.pf_busy, 0);
        chk("async_reset_active", bus.active_buffer, 0);
        ref_act = 0;
        addrq.delete();
        tick(); tick();
        reset_n = 1'b1;
        tick();
        do_prefetch(2, 10, 16'h3000, 3, 0, 1'b0);
        bus.swap_req = 1'b1; tick(); idle(); ref_act = 1 - ref_act;
        for (int i = 0; i < 3; i++) begin
            issue_read(2, 10 + i); tick(); idle();
        end

`ifdef WEIGHT_BUF_PARITY_EN
        begin
            rd_exp_t e;
            bus.wr_en = 1'b1; bus.wr_bank = '0; bus.wr_addr = AB'(500); bus.wr_data = 16'h00F0;
            tick(); idle();
            bus.swap_req = 1'b1; tick(); idle(); ref_act = 1 - ref_act;
            dut.mem_q[ref_act][0][500][0] = ~dut.mem_q[ref_act][0][500][0];
            bus.rd_en = 1'b1; bus.rd_bank = '0; bus.rd_addr = AB'(500);
            e.care = 1'b1; e.d = 16'h00F1; e.perr = 1'b1;
            rdq.push_back(e);
            tick(); idle();
        end
`endif

        // randomized traffic
        for (int op = 0; op < 400; op++) begin
            if ($urandom_range(0, 9) >= 8) begin
                int len;
                int ea;
                len = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 12);
                ea  = ($urandom_range(0, 3) == 0) ? 16'hFFFA : $urandom_range(0, 16'hFFFF);
                do_prefetch($urandom_range(0, NB - 1), rand_addr(), ea, len, 1, 1'b0);
            end else begin
                bit sw;
                sw = ($urandom_range(0, 7) == 0);
                if ($urandom_range(0, 1) == 1)
                    issue_write($urandom_range(0, NB - 1), rand_addr(), DB'($urandom));
                if ($urandom_range(0, 1) == 1)
                    issue_read($urandom_range(0, NB - 1), rand_addr());
                bus.swap_req = sw;
                tick(); idle();
                if (sw) ref_act = 1 - ref_act;
                chk("active_buffer", bus.active_buffer, ref_act);
            end
        end

        tick(); tick();
        chk("pf_done_count", n_done, exp_done);
        chk("wr_conflict_total", n_conf, 1);
        chk("rd_queue_drained", rdq.size(), 0);
        chk("addr_queue_drained", addrq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/banked_weight_buffer.md
Name: banked_weight_buffer

Overview:
Parametrised, double-buffered weight store for the matrix datapath, with NUM_BANKS banks of BANK_DEPTH entries per buffer.
- Compute reads the active buffer with 1-cycle latency.
- A built-in prefetch engine fills one bank of the shadow buffer from external memory over a valid/ready handshake.
- Buffer swaps are deferred until any in-flight prefetch completes.
- Sits between the global memory controller and the systolic/MAC array.

Parameters:
DATA_BITS, 16, entry width
NUM_BANKS, 4, banks per buffer (power of 2, >=2)
BANK_DEPTH, 1024, entries per bank (power of 2)
EXT_ADDR_BITS, 16, external memory address width

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
rd_en  in  1  read request, active buffer
rd_bank  in  $clog2(NUM_BANKS)  read bank
rd_addr  in  $clog2(BANK_DEPTH)  read entry
rd_data  out  DATA_BITS  read data
rd_valid  out  1  rd_data valid
wr_en  in  1  host write to shadow buffer
wr_bank  in  $clog2(NUM_BANKS)  write bank
wr_addr  in  $clog2(BANK_DEPTH)  write entry
wr_data  in  DATA_BITS  write data
wr_conflict  out  1  host write dropped this cycle
pf_start  in  1  prefetch start pulse
pf_bank  in  $clog2(NUM_BANKS)  shadow bank to fill
pf_local_addr  in  $clog2(BANK_DEPTH)  first entry in bank
pf_ext_addr  in  EXT_ADDR_BITS  first external address
pf_len  in  $clog2(BANK_DEPTH)+1  entries to fetch, 0..BANK_DEPTH
pf_busy  out  1  prefetch in progress
pf_done  out  1  1-cycle completion pulse
mem_read_valid  out  1  external read request
mem_read_address  out  EXT_ADDR_BITS  external address
mem_read_ready  in  1  response valid, data present
mem_read_data  in  DATA_BITS  response data
swap_req  in  1  swap request pulse
swap_pending  out  1  swap deferred
active_buffer  out  1  current active buffer index
parity_err  out  1  see Optional Feature

Behaviour:
- Reset (async, reset_n low): all outputs 0; FSM to IDLE; active_buffer=0; swap_pending=0.
  - Memory contents are not cleared.
  - Reset mid-prefetch aborts immediately; mem_read_valid drops asynchronously.
- Read: rd_en in cycle N gives rd_data=mem[active][rd_bank][rd_addr] and rd_valid=1 in cycle N+1. rd_valid is otherwise 0 and rd_data holds its last value.
- Host write: writes mem[~active][wr_bank][wr_addr] at the clock edge.
  - If the prefetch engine writes the same bank and entry in the same cycle, prefetch wins: host write dropped, wr_conflict=1 for that cycle.
- Prefetch FSM states: IDLE, REQ, DONE.
  - IDLE: pf_start with pf_len>0 latches bank, local addr, ext addr and remaining count; goes to REQ; pf_busy=1.
  - IDLE: pf_start with pf_len=0 goes straight to DONE.
  - IDLE: pf_start while busy is ignored.
  - REQ: mem_read_valid=1 with the current ext addr. One outstanding request only; address and valid stay stable until mem_read_ready.
  - On mem_read_ready: write mem_read_data to shadow[bank][local]; local increments modulo BANK_DEPTH (wrap within the bank); ext addr increments modulo 2^EXT_ADDR_BITS; count decrements. Count reaching 0 goes to DONE and drops mem_read_valid the same edge.
  - DONE: pf_done=1 for one cycle, pf_busy=0, then IDLE.
  - The shadow target is captured at start; a swap cannot occur mid-prefetch.
- Swap:
  - swap_req while pf_busy=0 toggles active_buffer at the next edge.
  - swap_req while pf_busy=1 sets swap_pending. The toggle happens on the edge leaving DONE, and swap_pending clears then.
  - A duplicate swap_req while pending is absorbed (single toggle).
  - Swap and a read in the same cycle: the read uses the pre-swap buffer.

Optional Feature:
- Macro WEIGHT_BUF_PARITY_EN.
- Defined:
  - Each entry stores an extra even-parity bit, computed on every write (host and prefetch).
  - A read recomputes parity; on mismatch, parity_err=1 alongside rd_valid for that cycle.
  - Data is returned unmodified.
- Undefined: no parity storage; parity_err tied 0.

Test Plan:
- Reset, then rd_en bank0 addr0 -> rd_valid=1 one cycle later; wr_conflict, pf_busy, pf_done, mem_read_valid all 0; active_buffer=0.
- Host writes 0x1234 to bank2 addr5, swap_req, then rd_en bank2 addr5 -> rd_data=0x1234, active_buffer=1.
- pf_start bank1, local 1022, ext 0x0100, len 4; memory returns 0xA0..0xA3 with 1-cycle ready delay -> addresses 0x0100..0x0103 issued one at a time; data lands at entries 1022, 1023, 0, 1; pf_done pulses once; after swap, reads confirm.
- swap_req during the prefetch -> swap_pending=1, active_buffer unchanged until the edge after pf_done, then toggles once; a second swap_req during pending is ignored.
- Host write and prefetch write to the same shadow entry in the same cycle -> prefetch data stored, wr_conflict=1; pf_len=0 -> pf_done next cycle, no mem_read_valid.
- reset_n low while mem_read_valid=1 -> mem_read_valid drops immediately; after release FSM is IDLE and a new pf_start works. With WEIGHT_BUF_PARITY_EN defined, a forced stored-bit flip -> parity_err=1 on read.
